// File: rtl/rf_base_stack.sv
// Register-file base pointer with a small stack of saved frame bases.
// A push saves the current base and moves the base forward by the frame
// size. A pop brings back the most recently saved base. Illegal requests
// leave all state alone and raise a sticky error flag instead.
module rf_base_stack #(
    parameter int MDATAW = 8,
    parameter int SDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    input  logic [MDATAW-1:0]            din,
    output logic [MDATAW-1:0]            base,
    output logic [$clog2(SDEPTH+1)-1:0]  count,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int CW = $clog2(SDEPTH+1);
    localparam int IW = $clog2(SDEPTH);

    logic [MDATAW-1:0] stack_mem [SDEPTH];

    logic          multi_op;
    logic          do_ld;
    logic          do_push;
    logic          do_pop;
    logic          err_set;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;

    // Decode the request into at most one legal action, or an error.
    // count is one bit wider than the entry index only when SDEPTH is a
    // power of two. In that case the top bit is set only when the stack
    // is full, and no push happens then. So push_idx drops that bit, and
    // pop_idx wraps modulo SDEPTH, which points at the top entry.
    always_comb begin
        full     = (count == CW'(SDEPTH));
        empty    = (count == '0);
        multi_op = (ld & push) | (ld & pop) | (push & pop);
        do_ld    = ld   & ~multi_op;
        do_push  = push & ~multi_op & ~full;
        do_pop   = pop  & ~multi_op & ~empty;
        err_set  = multi_op | (push & ~multi_op & full) | (pop & ~multi_op & empty);
        push_idx = count[IW-1:0];
        pop_idx  = push_idx - IW'(1);
    end

    // Saved-base storage. It is never reset, because entries at or above
    // count can never reach base. The write is skipped while reset is
    // high, so a discarded push leaves no trace.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            stack_mem[push_idx] <= base;
        end
    end

    // Base pointer and entry count. At most one action applies per cycle,
    // and any error case holds both values. The frame-size add wraps at
    // MDATAW bits on purpose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base  <= '0;
            count <= '0;
        end else if (do_ld) begin
            base <= din;
        end else if (do_push) begin
            base  <= base + din;
            count <= count + CW'(1);
        end else if (do_pop) begin
            base  <= stack_mem[pop_idx];
            count <= count - CW'(1);
        end
    end

    // Sticky error flag. A new error in the same cycle as clr_err wins,
    // so an error is never lost to a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_base_stack.sv
// Self-checking bench for rf_base_stack. It uses directed scenarios plus
// randomized traffic. All results are checked against a queue-based
// frame model.
module tb_rf_base_stack;

    localparam int MDATAW = 8;
    localparam int SDEPTH = 4;
    localparam int CW     = $clog2(SDEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              ld;
    logic              push;
    logic              pop;
    logic              clr_err;
    logic [MDATAW-1:0] din;
    logic [MDATAW-1:0] base;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              err;

    int checks   = 0;
    int failures = 0;

    // Reference model: the current base, a queue of saved bases, and the
    // sticky error flag.
    logic [MDATAW-1:0] m_base;
    logic [MDATAW-1:0] m_stack [$];
    logic              m_err;

    typedef struct packed {
        logic              l;
        logic              p;
        logic              o;
        logic              c;
        logic [MDATAW-1:0] d;
    } op_t;

    rf_base_stack #(.MDATAW(MDATAW), .SDEPTH(SDEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .push    (push),
        .pop     (pop),
        .clr_err (clr_err),
        .din     (din),
        .base    (base),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .err     (err)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Build one request word for the scenario tables.
    function automatic op_t mk(input logic l, input logic p, input logic o,
                               input logic c, input logic [MDATAW-1:0] d);
        op_t r;
        r.l = l; r.p = p; r.o = o; r.c = c; r.d = d;
        return r;
    endfunction

    // Return the model to its post-reset state.
    function automatic void model_reset();
        m_base = '0;
        m_stack.delete();
        m_err = 1'b0;
    endfunction

    // Advance the model by one clock edge, using the frame rules directly.
    function automatic void model_step(input op_t op);
        int  n;
        logic e;
        n = int'(op.l) + int'(op.p) + int'(op.o);
        e = 1'b0;
        if (n > 1) begin
            e = 1'b1;
        end else if (op.l) begin
            m_base = op.d;
        end else if (op.p) begin
            if (m_stack.size() == SDEPTH) begin
                e = 1'b1;
            end else begin
                m_stack.push_back(m_base);
                m_base = m_base + op.d;
            end
        end else if (op.o) begin
            if (m_stack.size() == 0) begin
                e = 1'b1;
            end else begin
                m_base = m_stack.pop_back();
            end
        end
        if (e) m_err = 1'b1;
        else if (op.c) m_err = 1'b0;
    endfunction

    // Expected {base, count, full, empty, err} taken from the model.
    function automatic logic [MDATAW+CW+2:0] model_expect();
        int n;
        n = m_stack.size();
        return {m_base, CW'(n), (n == SDEPTH), (n == 0), m_err};
    endfunction

    // Drive one request. Wait for the edge that takes it, then move 1 ns
    // past that edge so the registered outputs are settled.
    task automatic applyStimulus(input op_t op);
        ld = op.l; push = op.p; pop = op.o; clr_err = op.c; din = op.d;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges with the inputs idle, then resync
    // the model.
    task automatic pulse_reset();
        ld = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Check the outputs while reset is held at time zero.
    task automatic test_reset();
        model_reset();
        #2;
        checks++;
        if ({base, count, full, empty, err} !== model_expect()) begin
            failures++;
            $display("[TB] FAIL reset actual=%h expected=%h", {base, count, full, empty, err}, model_expect());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Load, two pushes, then pops down past empty.
    task automatic test_frame_basic();
        op_t ops[$];
        pulse_reset();
        ops.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h10));
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h08));
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h04));
        ops.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        ops.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        ops.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            model_step(ops[i]);
            checks++;
            if ({base, count, full, empty, err} !== model_expect()) begin
                failures++;
                $display("[TB] FAIL frame_basic[%0d] actual=%h expected=%h", i, {base, count, full, empty, err}, model_expect());
            end
        end
    endtask

    // Push until full, push once more to overflow, then clear the error.
    task automatic test_overflow();
        op_t ops[$];
        pulse_reset();
        for (int k = 0; k < 5; k++) ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h01));
        ops.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            model_step(ops[i]);
            checks++;
            if ({base, count, full, empty, err} !== model_expect()) begin
                failures++;
                $display("[TB] FAIL overflow[%0d] actual=%h expected=%h", i, {base, count, full, empty, err}, model_expect());
            end
        end
    endtask

    // The frame-size add wraps silently at the data width.
    task automatic test_wrap();
        op_t ops[$];
        pulse_reset();
        ops.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hFC));
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h08));
        ops.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            model_step(ops[i]);
            checks++;
            if ({base, count, full, empty, err} !== model_expect()) begin
                failures++;
                $display("[TB] FAIL wrap[%0d] actual=%h expected=%h", i, {base, count, full, empty, err}, model_expect());
            end
        end
    endtask

    // Combined requests are illegal. When an error and clr_err arrive
    // together, the error wins. A clear during a legal op still clears.
    task automatic test_illegal();
        op_t ops[$];
        pulse_reset();
        ops.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h40));
        ops.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h20));
        ops.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h05));
        ops.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h07));
        ops.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h09));
        ops.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h0A));
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h03));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            model_step(ops[i]);
            checks++;
            if ({base, count, full, empty, err} !== model_expect()) begin
                failures++;
                $display("[TB] FAIL illegal[%0d] actual=%h expected=%h", i, {base, count, full, empty, err}, model_expect());
            end
        end
    endtask

    // Push and pop alternate on consecutive cycles with no idle gaps.
    task automatic test_back_to_back();
        op_t ops[$];
        pulse_reset();
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom)));
        ops.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom)));
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom)));
        ops.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        ops.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom)));
        ops.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        ops.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            model_step(ops[i]);
            checks++;
            if ({base, count, full, empty, err} !== model_expect()) begin
                failures++;
                $display("[TB] FAIL back_to_back[%0d] actual=%h expected=%h", i, {base, count, full, empty, err}, model_expect());
            end
        end
    endtask

    // Fill to full depth, then drain. The base must end where it started.
    task automatic test_lifo();
        logic [MDATAW-1:0] start;
        op_t op;
        pulse_reset();
        start = 8'($urandom);
        op = mk(1'b1, 1'b0, 1'b0, 1'b0, start);
        applyStimulus(op);
        model_step(op);
        for (int k = 0; k < 2 * SDEPTH; k++) begin
            op = (k < SDEPTH) ? mk(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom))
                              : mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            applyStimulus(op);
            model_step(op);
            checks++;
            if ({base, count, full, empty, err} !== model_expect()) begin
                failures++;
                $display("[TB] FAIL lifo[%0d] actual=%h expected=%h", k, {base, count, full, empty, err}, model_expect());
            end
        end
        checks++;
        if (base !== start) begin
            failures++;
            $display("[TB] FAIL lifo_return base actual=%h expected=%h", base, start);
        end
    endtask

    // Assert reset between clock edges. Outputs must clear before the next
    // edge, a request held through reset must be dropped, and the first op
    // afterwards must start from the reset state.
    task automatic test_async_reset();
        op_t op;
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            op = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
            applyStimulus(op);
            model_step(op);
        end
        @(negedge clk);
        ld = 1'b1; push = 1'b0; pop = 1'b0; din = 8'hAA;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({base, count, full, empty, err} !== model_expect()) begin
            failures++;
            $display("[TB] FAIL async_reset actual=%h expected=%h", {base, count, full, empty, err}, model_expect());
        end
        @(posedge clk);
        #1;
        checks++;
        if ({base, count, full, empty, err} !== model_expect()) begin
            failures++;
            $display("[TB] FAIL reset_hold actual=%h expected=%h", {base, count, full, empty, err}, model_expect());
        end
        @(negedge clk);
        rst = 1'b0; ld = 1'b0;
        op = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
        applyStimulus(op);
        model_step(op);
        checks++;
        if ({base, count, full, empty, err} !== model_expect()) begin
            failures++;
            $display("[TB] FAIL post_reset actual=%h expected=%h", {base, count, full, empty, err}, model_expect());
        end
    endtask

    // Weighted random traffic: mostly legal ops, with some combined
    // requests, idle cycles and clears mixed in.
    task automatic test_random();
        op_t op;
        int  sel;
        pulse_reset();
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 15));
            op  = mk(1'b0, 1'b0, 1'b0, ($urandom_range(0, 7) == 0), 8'($urandom));
            if (sel < 3) op.l = 1'b1;
            else if (sel < 9) op.p = 1'b1;
            else if (sel < 14) op.o = 1'b1;
            else if (sel == 14) begin
                op.l = 1'($urandom); op.p = 1'b1; op.o = ~op.l;
            end
            applyStimulus(op);
            model_step(op);
            checks++;
            if ({base, count, full, empty, err} !== model_expect()) begin
                failures++;
                $display("[TB] FAIL random[%0d] actual=%h expected=%h", k, {base, count, full, empty, err}, model_expect());
            end
        end
    endtask

    // Run the scenarios in order, then print the summary.
    initial begin
        rst = 1'b1;
        ld = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
        test_reset();
        test_frame_basic();
        test_overflow();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_lifo();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_base_stack.md
RF_BASE_STACK -- requirements
Module: rf_base_stack

Interface
REQ-001 Parameter MDATAW, default 8: width of base pointer, data input and stack entries.
REQ-002 Parameter SDEPTH, default 4: number of saved-frame entries (>=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ld  input  1  load base pointer from din (SRF-instruction set).
REQ-006 push  input  1  open new frame: save current base, advance base by din.
REQ-007 pop  input  1  close frame: restore most recently saved base.
REQ-008 clr_err  input  1  clear sticky error flag.
REQ-009 din  input  MDATAW  load value (ld) or frame size (push).
REQ-010 base  output  MDATAW  current register-file base; drives the offset-adder "in" operand.
REQ-011 count  output  $clog2(SDEPTH+1)  number of saved entries.
REQ-012 full  output  1  high when count == SDEPTH.
REQ-013 empty  output  1  high when count == 0.
REQ-014 err  output  1  sticky illegal-operation flag.

Function
REQ-015 base, count and err SHALL be registered; full and empty SHALL be combinational decodes of count.
REQ-016 Every operation SHALL take effect at the first rising clk edge with the request high; the result SHALL be visible on base/count the same cycle after that edge (1-cycle latency, no stall).
REQ-017 Legal op = exactly one of ld, push, pop high; none high = hold all state.
REQ-018 ld: base <= din; count and stack contents unchanged.
REQ-019 push (not full): stack[count] <= base; base <= (base + din) mod 2^MDATAW; count <= count+1.
REQ-020 pop (not empty): base <= stack[count-1]; count <= count-1; entry contents need not be cleared.
REQ-021 push while full SHALL leave base, count and stack unchanged and set err.
REQ-022 pop while empty SHALL leave base, count and stack unchanged and set err.
REQ-023 Two or more of ld/push/pop high in one cycle SHALL be an illegal op: no state change, err set.
REQ-024 Addition SHALL wrap silently at MDATAW bits; wrap SHALL NOT set err.
REQ-025 err SHALL stay high until clr_err or rst; clr_err and a new error in the same cycle SHALL leave err high (set wins).
REQ-026 clr_err SHALL not affect base, count or stack and may coincide with any legal op.
REQ-027 Push immediately after pop (and vice versa) on consecutive cycles SHALL be supported with no bubble.
REQ-028 Full push to SDEPTH then full pop to 0 SHALL return base to its value before the first push (LIFO order).

Reset
REQ-029 rst high SHALL immediately, independent of clk, force base=0, count=0, err=0 (hence empty=1, full=0).
REQ-030 Stack entry storage need not be reset; entries above count SHALL never be observable on base.
REQ-031 rst asserted during any operation SHALL discard it; first op after rst deasserts SHALL act on reset state.

Verification
REQ-032 rst; ld din=0x10; push din=0x08; push din=0x04 -> base 0x10, 0x18, 0x1C; count 0,1,2; err 0.
REQ-033 From REQ-032 state: pop; pop -> base 0x18 then 0x10; count 1 then 0, empty=1; third pop -> base 0x10 unchanged, err=1.
REQ-034 SDEPTH=4, base 0: push din=1 five times -> base 1,2,3,4 then stays 4, count 4, full=1, err=1 on fifth; clr_err -> err 0.
REQ-035 ld din=0xFC; push din=0x08 -> base 0x04 (wrap), count 1, err 0; pop -> base 0xFC.
REQ-036 ld and push high together with din=0x20 -> base, count unchanged, err=1; same cycle clr_err high -> err still 1.
REQ-037 After two pushes, assert rst mid-cycle asynchronously -> base 0, count 0, empty 1, err 0 before next clk edge.
